// File: rtl/adc_stream_router_pkg.sv
// Shared router definitions: entry width helper, default entry field positions and path states.
// Also used by adc_input and sram_wrapper.
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } path_state_e;

  localparam int unsigned DEF_PRECISION  = 11;
  localparam int unsigned DEF_PIXEL_SIZE = 16;

  function automatic int unsigned entry_width(input int unsigned prec, input int unsigned psize);
    return 2 * prec + psize;
  endfunction

  // Field MSBs of the default {x, y, data} entry layout
  localparam int unsigned X_MSB    = entry_width(DEF_PRECISION, DEF_PIXEL_SIZE) - 1;
  localparam int unsigned Y_MSB    = X_MSB - DEF_PRECISION;
  localparam int unsigned DATA_MSB = DEF_PIXEL_SIZE - 1;

endpackage

// File: rtl/adc_stream_router_channel_loss_detector.sv
// Flags a channel as lost once its FIFO has been empty for LOSS_TIMEOUT consecutive cycles.
module channel_loss_detector #(
  parameter int unsigned LOSS_TIMEOUT = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_empty,
  output logic o_lost
);

  localparam int unsigned CW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOSS_TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_empty) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lost = (r_cnt == CNT_MAX);

endmodule

// File: rtl/adc_stream_router.sv
// Drains the ADC channel FIFOs, steering one channel to the background pipeline and one to the
// SRAM frame-writer; source changes are deferred to the next frame start (pixel 0,0).
module adc_stream_router
  import router_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned SEL_WIDTH    = 1,
  parameter int unsigned PRECISION    = 11,
  parameter int unsigned PIXEL_SIZE   = 16,
  parameter int unsigned LOSS_TIMEOUT = 4096,
  localparam int unsigned W = entry_width(PRECISION, PIXEL_SIZE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CHANNELS*W-1:0] i_ch_fifo_data,
  input  logic [NUM_CHANNELS-1:0]   i_ch_fifo_empty,
  output logic [NUM_CHANNELS-1:0]   o_ch_fifo_read,
  input  logic [SEL_WIDTH-1:0]      i_ctrl_bg_select,
  input  logic [SEL_WIDTH-1:0]      i_ctrl_fg_select,
  input  logic                      i_ctrl_fg_freeze,
  output logic [PRECISION-1:0]      o_bg_pixel_x,
  output logic [PRECISION-1:0]      o_bg_pixel_y,
  output logic [PIXEL_SIZE-1:0]     o_bg_pixel_data,
  output logic                      o_bg_pixel_ready,
  output logic [W-1:0]              o_fg_pixel_data,
  output logic                      o_fg_pixel_ready,
  input  logic                      i_fg_pixel_read,
  output logic [NUM_CHANNELS-1:0]   o_ch_lost,
  output logic [15:0]               o_fg_drop_count
);

  logic [W-1:0]            w_head [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_origin;
  logic [NUM_CHANNELS-1:0] w_lost;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_head[g]   = i_ch_fifo_data[g*W +: W];
    assign w_origin[g] = !i_ch_fifo_empty[g] && (w_head[g][W-1 -: PRECISION] == '0) &&
                         (w_head[g][PIXEL_SIZE +: PRECISION] == '0);

    channel_loss_detector #(
      .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) u_loss (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_empty(i_ch_fifo_empty[g]),
      .o_lost (w_lost[g])
    );
  end

  assign o_ch_lost = w_lost;

  logic [SEL_WIDTH-1:0] r_bg_sel, r_fg_sel, w_bg_sel, w_fg_sel;
  path_state_e          w_bg_mode, w_fg_mode;
  logic                 w_bg_go, w_fg_go;

  // Background path: switch lands on the cycle the target shows frame start or is lost.
  always_comb begin
    w_bg_mode = IDLE;
    w_bg_go   = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(i_ctrl_bg_select) == i && i_ctrl_bg_select != r_bg_sel && !i_rst) begin
        w_bg_mode = WAIT;
        w_bg_go   = w_origin[i] | w_lost[i];
      end
    end
    w_bg_sel = (w_bg_mode == WAIT && w_bg_go) ? i_ctrl_bg_select : r_bg_sel;
  end

  // Foreground path: same rule, independent of the background request.
  always_comb begin
    w_fg_mode = IDLE;
    w_fg_go   = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(i_ctrl_fg_select) == i && i_ctrl_fg_select != r_fg_sel && !i_rst) begin
        w_fg_mode = WAIT;
        w_fg_go   = w_origin[i] | w_lost[i];
      end
    end
    w_fg_sel = (w_fg_mode == WAIT && w_fg_go) ? i_ctrl_fg_select : r_fg_sel;
  end

  logic                    r_fg_valid;
  logic                    w_fg_space;
  logic [NUM_CHANNELS-1:0] w_pop;
  logic                    w_bg_pop, w_fg_pop;
  logic [W-1:0]            w_bg_entry, w_fg_entry;

  assign w_fg_space = !r_fg_valid || i_fg_pixel_read;

  always_comb begin
    w_pop      = '0;
    w_bg_pop   = 1'b0;
    w_fg_pop   = 1'b0;
    w_bg_entry = '0;
    w_fg_entry = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(w_fg_sel) == i && 32'(w_bg_sel) != i) begin
        w_pop[i] = !i_ch_fifo_empty[i] && (i_ctrl_fg_freeze || w_fg_space);
      end else begin
        w_pop[i] = !i_ch_fifo_empty[i];
      end
      if (32'(w_bg_sel) == i) begin
        w_bg_pop   = w_pop[i];
        w_bg_entry = w_head[i];
      end
      if (32'(w_fg_sel) == i) begin
        w_fg_pop   = w_pop[i];
        w_fg_entry = w_head[i];
      end
    end
    if (i_rst) begin
      w_pop    = '0;
      w_bg_pop = 1'b0;
      w_fg_pop = 1'b0;
    end
  end

  assign o_ch_fifo_read = w_pop;

  logic w_fg_load, w_fg_drop;

  // A drop can only happen when fg shares the bg channel, since fg-only pops wait for space.
  assign w_fg_load = w_fg_pop && !i_ctrl_fg_freeze && w_fg_space;
  assign w_fg_drop = w_fg_pop && !i_ctrl_fg_freeze && !w_fg_space;

  logic [PRECISION-1:0]  r_bg_x, r_bg_y;
  logic [PIXEL_SIZE-1:0] r_bg_data;
  logic                  r_bg_valid;
  logic [W-1:0]          r_fg_data;
  logic [15:0]           r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bg_sel   <= '0;
      r_fg_sel   <= '0;
      r_bg_valid <= 1'b0;
      r_bg_x     <= '0;
      r_bg_y     <= '0;
      r_bg_data  <= '0;
      r_fg_valid <= 1'b0;
      r_fg_data  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_bg_sel   <= w_bg_sel;
      r_fg_sel   <= w_fg_sel;
      r_bg_valid <= w_bg_pop;
      if (w_bg_pop) begin
        r_bg_x    <= w_bg_entry[W-1 -: PRECISION];
        r_bg_y    <= w_bg_entry[PIXEL_SIZE +: PRECISION];
        r_bg_data <= w_bg_entry[PIXEL_SIZE-1:0];
      end
      if (i_ctrl_fg_freeze) begin
        r_fg_valid <= 1'b0;
        r_fg_data  <= '0;
      end else if (w_fg_load) begin
        r_fg_valid <= 1'b1;
        r_fg_data  <= w_fg_entry;
      end else if (i_fg_pixel_read) begin
        r_fg_valid <= 1'b0;
      end
      if (w_fg_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_bg_pixel_x     = r_bg_x;
  assign o_bg_pixel_y     = r_bg_y;
  assign o_bg_pixel_data  = r_bg_data;
  assign o_bg_pixel_ready = r_bg_valid;
  assign o_fg_pixel_data  = r_fg_data;
  assign o_fg_pixel_ready = r_fg_valid;
  assign o_fg_drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_adc_stream_router.sv
// Directed bench for adc_stream_router with two channels and a 2-bit select.
module tb_adc_stream_router;

  localparam int unsigned NC = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned W  = 38;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d0, d1;
  logic [NC-1:0] empty, rd, lost;
  logic [SW-1:0] bg_req, fg_req;
  logic          freeze, fg_read;
  logic [10:0]   bg_x, bg_y;
  logic [15:0]   bg_data, drops;
  logic          bg_rdy, fg_rdy;
  logic [W-1:0]  fg_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_stream_router #(
    .NUM_CHANNELS(NC),
    .SEL_WIDTH   (SW),
    .PRECISION   (11),
    .PIXEL_SIZE  (16),
    .LOSS_TIMEOUT(4096)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ch_fifo_data  ({d1, d0}),
    .i_ch_fifo_empty (empty),
    .o_ch_fifo_read  (rd),
    .i_ctrl_bg_select(bg_req),
    .i_ctrl_fg_select(fg_req),
    .i_ctrl_fg_freeze(freeze),
    .o_bg_pixel_x    (bg_x),
    .o_bg_pixel_y    (bg_y),
    .o_bg_pixel_data (bg_data),
    .o_bg_pixel_ready(bg_rdy),
    .o_fg_pixel_data (fg_data),
    .o_fg_pixel_ready(fg_rdy),
    .i_fg_pixel_read (fg_read),
    .o_ch_lost       (lost),
    .o_fg_drop_count (drops)
  );

  function automatic logic [W-1:0] ent(input logic [10:0] x, input logic [10:0] y,
                                       input logic [15:0] d);
    return {x, y, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; empty = 2'b00; d0 = '0; d1 = '0;
    bg_req = '0; fg_req = '0; freeze = 1'b0; fg_read = 1'b0;
    #1;
    chk("rd_in_reset", 64'(rd), 64'h0);
    tick();
    tick();

    // Reset release, all FIFOs empty
    rst = 1'b0; empty = 2'b11;
    #1;
    chk("rst_bg_rdy", 64'(bg_rdy), 64'h0);
    chk("rst_bg_pix", 64'({bg_x, bg_y, bg_data}), 64'h0);
    chk("rst_fg_rdy", 64'(fg_rdy), 64'h0);
    chk("rst_fg_data", 64'(fg_data), 64'h0);
    chk("rst_lost", 64'(lost), 64'h0);
    chk("rst_drops", 64'(drops), 64'h0);
    repeat (4095) tick();
    chk("lost_4095", 64'(lost), 64'h0);
    tick();
    chk("lost_4096", 64'(lost), 64'h3);

    // One non-empty cycle on channel 1 (unselected, drained)
    empty = 2'b01; d1 = ent(11'd7, 11'd7, 16'h7777);
    #1;
    chk("drain_ch1_rd", 64'(rd), 64'h2);
    tick();
    chk("lost_ch1_clr", 64'(lost), 64'h1);
    chk("drain_no_bg", 64'(bg_rdy), 64'h0);

    // Channel 0 streams to bg and shared fg; fg_read held low
    empty = 2'b10; d0 = ent(11'd5, 11'd3, 16'hF800);
    #1;
    chk("bg_pop_rd", 64'(rd), 64'h1);
    tick();
    chk("bg1_rdy", 64'(bg_rdy), 64'h1);
    chk("bg1_pix", 64'({bg_x, bg_y, bg_data}), 64'({11'd5, 11'd3, 16'hF800}));
    chk("fg1_rdy", 64'(fg_rdy), 64'h1);
    chk("fg1_data", 64'(fg_data), 64'(ent(11'd5, 11'd3, 16'hF800)));
    chk("lost_ch0_clr", 64'(lost), 64'h0);
    d0 = ent(11'd6, 11'd3, 16'h07E0);
    tick();
    chk("bg2_data", 64'(bg_data), 64'h07E0);
    chk("drop1", 64'(drops), 64'h1);
    d0 = ent(11'd7, 11'd3, 16'h001F);
    tick();
    chk("fg_held", 64'(fg_data), 64'(ent(11'd5, 11'd3, 16'hF800)));
    chk("drop2", 64'(drops), 64'h2);
    d0 = ent(11'd8, 11'd3, 16'h1234); fg_read = 1'b1;
    tick();
    chk("fg_b2b_rdy", 64'(fg_rdy), 64'h1);
    chk("fg_b2b_data", 64'(fg_data), 64'(ent(11'd8, 11'd3, 16'h1234)));
    chk("drop_keep", 64'(drops), 64'h2);
    empty = 2'b11;
    tick();
    chk("fg_read_clr", 64'(fg_rdy), 64'h0);
    chk("bg_idle", 64'(bg_rdy), 64'h0);

    // Freeze while an fg entry is held
    fg_read = 1'b0; empty = 2'b10; d0 = ent(11'd9, 11'd3, 16'hABCD);
    tick();
    chk("fg5_rdy", 64'(fg_rdy), 64'h1);
    freeze = 1'b1; d0 = ent(11'd10, 11'd3, 16'hBEEF);
    #1;
    chk("frz_rd", 64'(rd), 64'h1);
    tick();
    chk("frz_fg_rdy", 64'(fg_rdy), 64'h0);
    chk("frz_fg_data", 64'(fg_data), 64'h0);
    chk("frz_drops", 64'(drops), 64'h2);
    chk("frz_bg_data", 64'(bg_data), 64'hBEEF);
    freeze = 1'b0; empty = 2'b11;
    tick();

    // bg 0 -> 1 mid-frame: old channel served until channel 1 shows (0,0)
    bg_req = 2'd1; fg_read = 1'b1; empty = 2'b00;
    d0 = ent(11'd10, 11'd4, 16'h1111); d1 = ent(11'd3, 11'd2, 16'h2222);
    #1;
    chk("wait_rd", 64'(rd), 64'h3);
    tick();
    chk("wait_bg_old", 64'({bg_x, bg_y, bg_data}), 64'({11'd10, 11'd4, 16'h1111}));
    d0 = ent(11'd11, 11'd4, 16'h3333); d1 = ent(11'd0, 11'd0, 16'h5555);
    tick();
    chk("sw_bg_new", 64'({bg_x, bg_y, bg_data}), 64'({11'd0, 11'd0, 16'h5555}));
    chk("sw_fg_only", 64'(fg_data), 64'(ent(11'd11, 11'd4, 16'h3333)));

    // fg-only channel with full register and no read: no pop
    fg_read = 1'b0; empty = 2'b10; d0 = ent(11'd12, 11'd4, 16'h4444);
    #1;
    chk("fgonly_hold_rd", 64'(rd), 64'h0);
    tick();
    chk("fgonly_held", 64'(fg_data), 64'(ent(11'd11, 11'd4, 16'h3333)));
    freeze = 1'b1;
    #1;
    chk("fgonly_frz_rd", 64'(rd), 64'h1);
    tick();
    chk("fgonly_frz_rdy", 64'(fg_rdy), 64'h0);
    chk("fgonly_frz_drops", 64'(drops), 64'h2);
    freeze = 1'b0; empty = 2'b11;
    tick();

    // Out-of-range fg request ignored: fg stays on channel 0
    fg_req = 2'd3; empty = 2'b10; d0 = ent(11'd13, 11'd4, 16'hCCCC);
    #1;
    chk("oor_rd", 64'(rd), 64'h1);
    tick();
    chk("oor_fg_data", 64'(fg_data), 64'(ent(11'd13, 11'd4, 16'hCCCC)));

    // Switch to a lost channel happens immediately
    fg_read = 1'b1; empty = 2'b11;
    repeat (4100) tick();
    chk("lost_both", 64'(lost), 64'h3);
    fg_req = 2'd1; fg_read = 1'b0;
    tick();
    empty = 2'b00; d0 = ent(11'd1, 11'd1, 16'hAAAA); d1 = ent(11'd2, 11'd2, 16'hBBBB);
    tick();
    chk("lostsw_fg_data", 64'(fg_data), 64'(ent(11'd2, 11'd2, 16'hBBBB)));
    chk("lostsw_bg_data", 64'(bg_data), 64'hBBBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
